// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite register bank: NUM_RO read-only words sourced from roIn, followed by read/write words.
// Define REG_BANK_WSTRB_EN to honour wstrb byte lanes; by default every write replaces the full word.
module axi_lite_reg_bank #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           NUM_REGS   = 8,
    parameter int unsigned           NUM_RO     = 2,
    parameter logic [DATA_WIDTH-1:0] RW_RESET   = '0
) (
    input  logic                                     clk,
    input  logic                                     rstN,
    input  logic [ADDR_WIDTH-1:0]                    awaddr,
    input  logic                                     awvalid,
    output logic                                     awready,
    input  logic [DATA_WIDTH-1:0]                    wdata,
    input  logic [DATA_WIDTH/8-1:0]                  wstrb,
    input  logic                                     wvalid,
    output logic                                     wready,
    output logic [1:0]                               bresp,
    output logic                                     bvalid,
    input  logic                                     bready,
    input  logic [ADDR_WIDTH-1:0]                    araddr,
    input  logic                                     arvalid,
    output logic                                     arready,
    output logic [DATA_WIDTH-1:0]                    rdata,
    output logic [1:0]                               rresp,
    output logic                                     rvalid,
    input  logic                                     rready,
    input  logic [NUM_RO*DATA_WIDTH-1:0]             roIn,
    output logic [(NUM_REGS-NUM_RO)*DATA_WIDTH-1:0]  rwOut,
    output logic [NUM_REGS-NUM_RO-1:0]               wrPulse
);
    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned NUM_RW   = NUM_REGS - NUM_RO;
    localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e                w_state_q, w_state_d;
    r_state_e                r_state_q, r_state_d;
    logic                    ready_en_q;
    logic                    aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [NUM_RW-1:0]       wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0]   rw_q [NUM_RW];
    logic [DATA_WIDTH-1:0]   rw_d [NUM_RW];
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;

    logic                    aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [STRB_W-1:0]       wr_strb;
    logic [IDX_W-1:0]        wr_idx, rd_idx;

    // Handshake rule: a beat transfers on a rising edge where valid and ready are both high.
    assign awready = ready_en_q && (w_state_q == W_IDLE) && !aw_got_q;
    assign wready  = ready_en_q && (w_state_q == W_IDLE) && !w_got_q;
    assign arready = ready_en_q && (r_state_q == R_IDLE);
    assign bvalid  = (w_state_q == W_RESP);
    assign rvalid  = (r_state_q == R_DATA);
    assign bresp   = bresp_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign wrPulse = wr_pulse_q;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;

    // A channel captured in an earlier cycle wins over the live bus value.
    assign wr_addr = aw_got_q ? awaddr_q : awaddr;
    assign wr_data = w_got_q ? wdata_q : wdata;
    assign wr_strb = w_got_q ? wstrb_q : wstrb;
    assign wr_idx  = wr_addr[ADDR_WIDTH-1:ADDR_LSB];
    assign rd_idx  = araddr[ADDR_WIDTH-1:ADDR_LSB];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};
`ifndef REG_BANK_WSTRB_EN
    logic unused_strb;
    assign unused_strb = ^wr_strb;
`endif

    always_comb begin
        w_state_d  = w_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        rw_d       = rw_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    awaddr_d = awaddr;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                    w_state_d = W_RESP;
                    if (32'(wr_idx) < NUM_RO) begin
                        bresp_d = RESP_SLVERR;
                    end else if (32'(wr_idx) >= NUM_REGS) begin
                        bresp_d = RESP_DECERR;
                    end else begin
                        bresp_d = RESP_OKAY;
                        for (int unsigned j = 0; j < NUM_RW; j++) begin
                            if (32'(wr_idx) == NUM_RO + j) begin
                                wr_pulse_d[j] = 1'b1;
`ifdef REG_BANK_WSTRB_EN
                                for (int unsigned k = 0; k < STRB_W; k++) begin
                                    if (wr_strb[k]) rw_d[j][8*k +: 8] = wr_data[8*k +: 8];
                                end
`else
                                rw_d[j] = wr_data;
`endif
                            end
                        end
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read data is frozen at the accept edge, so roIn may change while rvalid waits.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rdata_d   = '0;
                    rresp_d   = RESP_DECERR;
                    for (int unsigned i = 0; i < NUM_RO; i++) begin
                        if (32'(rd_idx) == i) begin
                            rdata_d = roIn[i*DATA_WIDTH +: DATA_WIDTH];
                            rresp_d = RESP_OKAY;
                        end
                    end
                    for (int unsigned j = 0; j < NUM_RW; j++) begin
                        if (32'(rd_idx) == NUM_RO + j) begin
                            rdata_d = rw_q[j];
                            rresp_d = RESP_OKAY;
                        end
                    end
                end
            end
            R_DATA: begin
                if (rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            ready_en_q <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            for (int unsigned j = 0; j < NUM_RW; j++) rw_q[j] <= RW_RESET;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            ready_en_q <= 1'b1;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rw_q       <= rw_d;
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
        assign rwOut[g*DATA_WIDTH +: DATA_WIDTH] = rw_q[g];
    end
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Directed bench for axi_lite_reg_bank (32-bit data, 8 registers, 2 read-only).
module tb_axi_lite_reg_bank;
    logic         clk = 1'b0;
    logic         rstN;
    logic [7:0]   awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [63:0]  roIn;
    logic [191:0] rwOut;
    logic [5:0]   wrPulse;

    int n_checks = 0;
    int n_pass   = 0;

    axi_lite_reg_bank dut (
        .clk(clk), .rstN(rstN),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .roIn(roIn), .rwOut(rwOut), .wrPulse(wrPulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first. Called and returns at a negedge.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int order, input int hold,
                             input logic [1:0] exp_resp, input logic [5:0] exp_pulse);
        logic aw_done, w_done, a_now, w_now;
        aw_done = 1'b0;
        w_done  = 1'b0;
        if (order != 2) begin awaddr = a; awvalid = 1'b1; end
        if (order != 1) begin wdata = d; wstrb = s; wvalid = 1'b1; end
        for (int k = 0; k < 20 && !(aw_done && w_done); k++) begin
            a_now = awvalid && awready;
            w_now = wvalid && wready;
            @(negedge clk);
            if (a_now) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_now) begin w_done = 1'b1; wvalid = 1'b0; end
            if (aw_done && !w_done) begin
                check("awready_low_after_aw", awready, 0);
                check("bvalid_low_half", bvalid, 0);
                if (!wvalid) begin wdata = d; wstrb = s; wvalid = 1'b1; end
            end
            if (w_done && !aw_done) begin
                check("wready_low_after_w", wready, 0);
                check("bvalid_low_half", bvalid, 0);
                if (!awvalid) begin awaddr = a; awvalid = 1'b1; end
            end
        end
        check("wr_handshake_done", aw_done && w_done, 1);
        check("bvalid_set", bvalid, 1);
        check("bresp", bresp, exp_resp);
        check("wrpulse_set", wrPulse, exp_pulse);
        check("awready_in_resp", awready, 0);
        check("wready_in_resp", wready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, exp_resp);
            check("readies_low_hold", {awready, wready}, 0);
            check("wrpulse_once", wrPulse, 0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
        check("wrpulse_clear", wrPulse, 0);
        check("awready_back", {awready, wready}, 2'b11);
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] exp_d,
                            input logic [1:0] exp_r, input int hold);
        logic done, now;
        logic [63:0] ro_save;
        done = 1'b0;
        araddr = a;
        arvalid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            now = arready;
            @(negedge clk);
            if (now) begin done = 1'b1; arvalid = 1'b0; end
        end
        check("rd_handshake_done", done, 1);
        check("rvalid_set", rvalid, 1);
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_r);
        ro_save = roIn;
        for (int h = 0; h < hold; h++) begin
            roIn = ~roIn;
            @(negedge clk);
            check("rdata_stable", rdata, exp_d);
            check("rvalid_hold", rvalid, 1);
            check("arready_low_hold", arready, 0);
        end
        roIn = ro_save;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_clear", rvalid, 0);
        check("arready_back", arready, 1);
    endtask

    initial begin
        logic [31:0] exp_strb;
        rstN = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        roIn = {32'h0BADF00D, 32'h0000_0000};

        repeat (3) @(negedge clk);
        check("rst_readies", {awready, wready, arready}, 0);
        check("rst_valids", {bvalid, rvalid}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_resps", {bresp, rresp}, 0);
        check("rst_wrpulse", wrPulse, 0);
        check("rst_rwout", |rwOut, 0);
        rstN = 1'b1;
        #1;
        check("readies_before_edge", {awready, wready, arready}, 0);
        @(negedge clk);
        check("readies_after_edge", {awready, wready, arready}, 3'b111);

        // AW before W, then readback
        axi_write(8'h08, 32'hDEADBEEF, 4'hF, 1, 0, 2'b00, 6'b000001);
        check("rwout_slice0", rwOut[31:0], 32'hDEADBEEF);
        axi_read(8'h08, 32'hDEADBEEF, 2'b00, 0);

        // W before AW with bready held low
        axi_write(8'h10, 32'h55AA1234, 4'hF, 2, 3, 2'b00, 6'b000100);
        check("rwout_slice2", rwOut[95:64], 32'h55AA1234);
        axi_read(8'h10, 32'h55AA1234, 2'b00, 0);

        // Read-only region
        axi_write(8'h00, 32'h00001234, 4'hF, 0, 0, 2'b10, 6'b000000);
        roIn[31:0] = 32'hCAFE0001;
        axi_read(8'h00, 32'hCAFE0001, 2'b00, 2);
        axi_read(8'h04, 32'h0BADF00D, 2'b00, 0);

        // Out of range
        axi_write(8'h20, 32'h77777777, 4'hF, 0, 0, 2'b11, 6'b000000);
        axi_read(8'h20, 32'h0, 2'b11, 0);
        check("rwout_no_decerr_change", rwOut[31:0], 32'hDEADBEEF);

        // Byte strobes
        axi_write(8'h0C, 32'h11223344, 4'hF, 0, 0, 2'b00, 6'b000010);
`ifdef REG_BANK_WSTRB_EN
        exp_strb = 32'h11BB33DD;
`else
        exp_strb = 32'hAABBCCDD;
`endif
        axi_write(8'h0C, 32'hAABBCCDD, 4'b0101, 1, 0, 2'b00, 6'b000010);
        axi_read(8'h0C, exp_strb, 2'b00, 0);
        check("rwout_slice1", rwOut[63:32], exp_strb);

        // Low address bits ignored; last register
        axi_write(8'h0B, 32'h01020304, 4'hF, 0, 0, 2'b00, 6'b000001);
        axi_read(8'h09, 32'h01020304, 2'b00, 0);
        axi_write(8'h1C, 32'hF00DFACE, 4'hF, 2, 0, 2'b00, 6'b100000);
        axi_read(8'h1F, 32'hF00DFACE, 2'b00, 0);

        // Read accepted on the same edge as a write commit to the same register
        awaddr = 8'h08; awvalid = 1'b1; wdata = 32'h99999999; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 8'h08; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("conc_bvalid", bvalid, 1);
        check("conc_rvalid", rvalid, 1);
        check("conc_rdata_old", rdata, 32'h01020304);
        check("conc_wrpulse", wrPulse, 6'b000001);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        check("conc_done", {bvalid, rvalid}, 0);
        axi_read(8'h08, 32'h99999999, 2'b00, 0);

        // Reset between the AW and W handshakes
        awaddr = 8'h14; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("mid_aw_captured", awready, 0);
        rstN = 1'b0;
        #1;
        check("mid_rst_readies", {awready, wready, arready}, 0);
        check("mid_rst_rwout", |rwOut, 0);
        wdata = 32'h12121212; wvalid = 1'b1;
        @(negedge clk);
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_wrpulse", wrPulse, 0);
        wvalid = 1'b0;
        rstN = 1'b1;
        #1;
        check("mid_release_readies_low", {awready, wready, arready}, 0);
        @(negedge clk);
        check("mid_release_readies", {awready, wready, arready}, 3'b111);
        check("mid_release_bvalid", bvalid, 0);
        axi_read(8'h14, 32'h0, 2'b00, 0);
        axi_read(8'h08, 32'h0, 2'b00, 0);
        axi_write(8'h14, 32'hABCD0123, 4'hF, 1, 0, 2'b00, 6'b001000);
        axi_read(8'h14, 32'hABCD0123, 2'b00, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
